// File: rtl/cache_ctrl.sv
// Set-associative cache tag controller: one request at a time through lookup,
// optional dirty-victim writeback, line fill and response, with true-LRU ages per set.
module cache_ctrl #(
    parameter int INDEX_SIZE    = 4,
    parameter int ASSOCIATIVITY = 2,
    parameter int TAG_WIDTH     = 8,
    localparam int COUNT_SIZE   = $clog2(ASSOCIATIVITY),
    localparam int NUM_INDICES  = $clog2(INDEX_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [NUM_INDICES-1:0] req_index,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    input  logic                   req_write,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [COUNT_SIZE-1:0]  resp_way,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [NUM_INDICES-1:0] mem_index,
    output logic [TAG_WIDTH-1:0]   mem_tag,
    input  logic                   mem_ack
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

    state_t                   state;
    logic [TAG_WIDTH-1:0]     tag_mem   [INDEX_SIZE][ASSOCIATIVITY];
    logic [ASSOCIATIVITY-1:0] valid_mem [INDEX_SIZE];
    logic [ASSOCIATIVITY-1:0] dirty_mem [INDEX_SIZE];
    logic [COUNT_SIZE-1:0]    age       [INDEX_SIZE][ASSOCIATIVITY];

    logic [NUM_INDICES-1:0]   cur_index;
    logic [TAG_WIDTH-1:0]     cur_tag;
    logic                     cur_write;
    logic [COUNT_SIZE-1:0]    victim_q;

    logic                     hit;
    logic [COUNT_SIZE-1:0]    hit_way;
    logic [COUNT_SIZE-1:0]    victim;
    logic                     found_invalid;
    logic [COUNT_SIZE-1:0]    touch_way;
    logic [COUNT_SIZE-1:0]    touched_age [ASSOCIATIVITY];

    assign req_ready = (state == IDLE);

    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        victim        = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (valid_mem[cur_index][w[COUNT_SIZE-1:0]] &&
                tag_mem[cur_index][w[COUNT_SIZE-1:0]] == cur_tag) begin
                hit     = 1'b1;
                hit_way = w[COUNT_SIZE-1:0];
            end
        end
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (!found_invalid && !valid_mem[cur_index][w[COUNT_SIZE-1:0]]) begin
                found_invalid = 1'b1;
                victim        = w[COUNT_SIZE-1:0];
            end
        end
        // With every way valid, evict the least recently used one.
        if (!found_invalid) begin
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                if (age[cur_index][w[COUNT_SIZE-1:0]] == COUNT_SIZE'(ASSOCIATIVITY - 1)) begin
                    victim = w[COUNT_SIZE-1:0];
                end
            end
        end
    end

    // Next ages of the addressed set if touch_way becomes MRU; only used in LOOKUP-hit and FILL.
    always_comb begin
        touch_way = (state == FILL) ? victim_q : hit_way;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (age[cur_index][w[COUNT_SIZE-1:0]] < age[cur_index][touch_way]) begin
                touched_age[w] = age[cur_index][w[COUNT_SIZE-1:0]] + COUNT_SIZE'(1);
            end else begin
                touched_age[w] = age[cur_index][w[COUNT_SIZE-1:0]];
            end
        end
        touched_age[touch_way] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_index  <= '0;
            mem_tag    <= '0;
            cur_index  <= '0;
            cur_tag    <= '0;
            cur_write  <= 1'b0;
            victim_q   <= '0;
            for (int s = 0; s < INDEX_SIZE; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                for (int w = 0; w < ASSOCIATIVITY; w++) begin
                    tag_mem[s][w] <= '0;
                    age[s][w]     <= w[COUNT_SIZE-1:0];
                end
            end
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_index <= req_index;
                        cur_tag   <= req_tag;
                        cur_write <= req_write;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        for (int w = 0; w < ASSOCIATIVITY; w++) begin
                            age[cur_index][w] <= touched_age[w];
                        end
                        if (cur_write) begin
                            dirty_mem[cur_index][hit_way] <= 1'b1;
                        end
                        resp_hit   <= 1'b1;
                        resp_way   <= hit_way;
                        resp_valid <= 1'b1;
                        state      <= RESPOND;
                    end else begin
                        victim_q  <= victim;
                        mem_req   <= 1'b1;
                        mem_index <= cur_index;
                        if (valid_mem[cur_index][victim] && dirty_mem[cur_index][victim]) begin
                            mem_we  <= 1'b1;
                            mem_tag <= tag_mem[cur_index][victim];
                            state   <= WRITEBACK;
                        end else begin
                            mem_we  <= 1'b0;
                            mem_tag <= cur_tag;
                            state   <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    // mem_req stays asserted straight into the fill.
                    if (mem_ack) begin
                        mem_we  <= 1'b0;
                        mem_tag <= cur_tag;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        tag_mem[cur_index][victim_q]   <= cur_tag;
                        valid_mem[cur_index][victim_q] <= 1'b1;
                        dirty_mem[cur_index][victim_q] <= cur_write;
                        for (int w = 0; w < ASSOCIATIVITY; w++) begin
                            age[cur_index][w] <= touched_age[w];
                        end
                        mem_req    <= 1'b0;
                        resp_hit   <= 1'b0;
                        resp_way   <= victim_q;
                        resp_valid <= 1'b1;
                        state      <= RESPOND;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: hits, clean and dirty misses, LRU victim choice,
// delayed acknowledges, ignored requests and asynchronous reset mid-fill.
module tb_cache_ctrl;

    localparam int IS = 4;
    localparam int AS = 2;
    localparam int TW = 8;
    localparam int CS = 1;
    localparam int NI = 2;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [NI-1:0] req_index;
    logic [TW-1:0] req_tag;
    logic          req_write;
    logic          resp_valid;
    logic          resp_hit;
    logic [CS-1:0] resp_way;
    logic          mem_req;
    logic          mem_we;
    logic [NI-1:0] mem_index;
    logic [TW-1:0] mem_tag;
    logic          mem_ack;

    int checks = 0;
    int errors = 0;

    cache_ctrl #(.INDEX_SIZE(IS), .ASSOCIATIVITY(AS), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_tag(req_tag), .req_write(req_write),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .mem_req(mem_req), .mem_we(mem_we), .mem_index(mem_index),
        .mem_tag(mem_tag), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic check_perm();
        for (int s = 0; s < IS; s++) begin
            logic [AS-1:0] seen;
            seen = '0;
            for (int j = 0; j < AS; j++) seen[dut.age[s][j]] = 1'b1;
            check($sformatf("age_perm_set%0d", s), 32'(seen), 32'(2**AS - 1));
        end
    endtask

    task automatic check_age_reset();
        for (int s = 0; s < IS; s++)
            for (int j = 0; j < AS; j++)
                check($sformatf("age_reset_%0d_%0d", s, j), 32'(dut.age[s][j]), 32'(j));
    endtask

    // Holds off the acknowledge for 'delay' cycles while poking req_valid, then acks once.
    task automatic mem_phase(input int delay, input logic [TW-1:0] want_tag, input logic want_we);
        for (int i = 0; i < delay; i++) begin
            req_valid = 1'b1;
            req_tag   = 8'hEE;
            @(negedge clk);
            req_valid = 1'b0;
            check("hold_mem_req", 32'(mem_req), 1);
            check("hold_mem_tag", 32'(mem_tag), 32'(want_tag));
            check("hold_mem_we", 32'(mem_we), 32'(want_we));
            check("hold_req_ready", 32'(req_ready), 0);
            check("hold_resp_valid", 32'(resp_valid), 0);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic access(input logic [NI-1:0] idx, input logic [TW-1:0] tag, input logic wr,
                          input logic want_hit, input logic [CS-1:0] want_way,
                          input logic want_wb, input logic [TW-1:0] wb_tag, input int delay);
        check("idle_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_index = idx;
        req_tag   = tag;
        req_write = wr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("lookup_ready", 32'(req_ready), 0);
        check("lookup_mem_req", 32'(mem_req), 0);
        check("lookup_resp_valid", 32'(resp_valid), 0);
        @(negedge clk);
        if (want_hit) begin
            check("hit_resp_valid", 32'(resp_valid), 1);
            check("hit_resp_hit", 32'(resp_hit), 1);
            check("hit_resp_way", 32'(resp_way), 32'(want_way));
            check("hit_mem_req", 32'(mem_req), 0);
        end else begin
            if (want_wb) begin
                check("wb_mem_req", 32'(mem_req), 1);
                check("wb_mem_we", 32'(mem_we), 1);
                check("wb_mem_tag", 32'(mem_tag), 32'(wb_tag));
                check("wb_mem_index", 32'(mem_index), 32'(idx));
                mem_phase(delay, wb_tag, 1'b1);
            end
            check("fill_mem_req", 32'(mem_req), 1);
            check("fill_mem_we", 32'(mem_we), 0);
            check("fill_mem_tag", 32'(mem_tag), 32'(tag));
            check("fill_mem_index", 32'(mem_index), 32'(idx));
            check("fill_resp_valid", 32'(resp_valid), 0);
            mem_phase(delay, tag, 1'b0);
            check("miss_mem_req_off", 32'(mem_req), 0);
            check("miss_resp_valid", 32'(resp_valid), 1);
            check("miss_resp_hit", 32'(resp_hit), 0);
            check("miss_resp_way", 32'(resp_way), 32'(want_way));
        end
        @(negedge clk);
        check("resp_pulse_end", 32'(resp_valid), 0);
        check("back_to_idle", 32'(req_ready), 1);
        check_perm();
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_index = '0;
        req_tag   = '0;
        req_write = 1'b0;
        mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_hit", 32'(resp_hit), 0);
        check("rst_resp_way", 32'(resp_way), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_index", 32'(mem_index), 0);
        check("rst_mem_tag", 32'(mem_tag), 0);
        reset = 1'b1;
        @(negedge clk);
        check_age_reset();

        // Stray acknowledge while idle must do nothing.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_mem_req", 32'(mem_req), 0);
        check("stray_ack_ready", 32'(req_ready), 1);
        check("stray_ack_resp", 32'(resp_valid), 0);

        // Set 0: cold miss then hit.
        access(2'd0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        access(2'd0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0);

        // Set 1: LRU replacement with clean victims.
        access(2'd1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        access(2'd1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        access(2'd1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0);
        access(2'd1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        access(2'd1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);

        // Set 2: dirty victim writeback, both acks delayed 5 cycles.
        access(2'd2, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        access(2'd2, 8'h21, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        access(2'd2, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 5);

        // Set 3 activity, including a dirty line made by a store miss.
        access(2'd3, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        access(2'd3, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        access(2'd3, 8'h35, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        access(2'd3, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0);
        access(2'd3, 8'h36, 1'b0, 1'b0, 1'b0, 1'b1, 8'h35, 0);

        // Set 0 victim choice unaffected by set 3.
        access(2'd0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        access(2'd0, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        access(2'd0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);

        // Asynchronous reset in the middle of a fill.
        check("pre_rst_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_index = 2'd1;
        req_tag   = 8'h77;
        req_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_fill_mem_req", 32'(mem_req), 1);
        #2 reset = 1'b0;
        #1;
        check("abort_mem_req_drop", 32'(mem_req), 0);
        check("abort_ready", 32'(req_ready), 1);
        check("abort_mem_tag", 32'(mem_tag), 0);
        check("abort_resp_valid", 32'(resp_valid), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_age_reset();
        access(2'd1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        access(2'd1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        access(2'd0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Set-associative cache tag controller that sequences one processor request at a time through lookup, optional dirty-victim writeback, line fill and response. It owns the tag/valid/dirty arrays and true-LRU age state per set. It sits between the processor request port and the next memory level, and is the block that drives replacement selection for the cache datapath. Policy is write-back, write-allocate; the data array lives outside this block and follows its way/state outputs.

## Interface
- INDEX_SIZE, 4, number of sets
- ASSOCIATIVITY, 2, ways per set; power of two, ≥2
- TAG_WIDTH, 8, tag bits
- Derived: COUNT_SIZE = $clog2(ASSOCIATIVITY), NUM_INDICES = $clog2(INDEX_SIZE)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  processor request present
- req_ready  out  1  controller idle; request accepted when req_valid & req_ready at a rising edge
- req_index  in  NUM_INDICES  set index
- req_tag  in  TAG_WIDTH  tag
- req_write  in  1  1 = store (line marked dirty), 0 = load
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  1 = request hit
- resp_way  out  COUNT_SIZE  way holding the line
- mem_req  out  1  next-level request, held until acknowledged
- mem_we  out  1  1 = writeback of victim, 0 = fill
- mem_index  out  NUM_INDICES  set of memory transfer
- mem_tag  out  TAG_WIDTH  tag of memory transfer
- mem_ack  in  1  next-level completion; sampled only while mem_req = 1

## Operation
- States: IDLE, LOOKUP, WRITEBACK, FILL, RESPOND. req_ready = (state == IDLE).
- IDLE: on accept, register index/tag/write → LOOKUP.
- LOOKUP (1 cycle): compare tag against all valid ways of the set.
  - Hit: touch hit way in LRU; set dirty if write; resp_hit←1, resp_way←hit way → RESPOND.
  - Miss: victim = lowest-numbered invalid way; if none, the way with age ASSOCIATIVITY-1. Victim valid and dirty → WRITEBACK (mem_tag←victim tag, mem_we←1); else → FILL (mem_tag←req tag, mem_we←0). mem_index←req index.
- WRITEBACK: mem_req = 1. On mem_ack: mem_tag←req tag, mem_we←0 → FILL.
- FILL: mem_req = 1. On mem_ack: victim tag←req tag, valid←1, dirty←req_write, touch victim in LRU; resp_hit←0, resp_way←victim → RESPOND.
- RESPOND: resp_valid = 1 → IDLE.
- LRU: per set, per way, COUNT_SIZE-bit age; 0 = MRU, ASSOCIATIVITY-1 = LRU. Ages of a set are always a permutation of 0..ASSOCIATIVITY-1. Touch way w: every way with age < age[w] increments; age[w]←0. Only the addressed set changes.
- Reset: all valid/dirty←0, tags←0, age[set][j]←j, state←IDLE, resp_valid/resp_hit/resp_way/mem_req/mem_we/mem_index/mem_tag←0. Reset is asynchronous: it aborts any state, including mid-transfer, and drops mem_req immediately. No pending transfer is remembered.

## Timing
- Hit: accept at edge 0; LOOKUP in cycle 1; resp_valid high in cycle 2. The next accept is possible at edge 3.
- Clean miss: mem_req rises in cycle 2. If mem_ack is sampled at edge N, mem_req is low and resp_valid is high in cycle N+1.
- Dirty miss: the writeback phase occupies cycles 2..N. mem_req stays high continuously into FILL, and mem_we changes 1→0 after the writeback ack. A fill ack is then required.
- mem_tag, mem_index and mem_we are stable for the whole time mem_req is high. mem_ack while mem_req = 0 is ignored.
- req_valid while req_ready = 0 is ignored. The request is not queued.
- All outputs are registered, except req_ready, which decodes the state.

## Test plan
- After reset, load idx0 tag 0x11: miss, clean fill (mem_we=0, mem_tag=0x11), resp_hit=0, resp_way=0. Repeat: resp_hit=1, way 0, resp_valid in the 2nd cycle after accept, no mem_req.
- Set 1 (ASSOCIATIVITY=2): load tags 0xA0, 0xB0 (ways 0,1), load 0xA0 again, then load 0xC0: victim way 1, no writeback, resp_way=1. A following load of 0xB0 misses.
- Set 2: store 0x20 (way 0, dirty), load 0x21 (way 1), load 0x22: WRITEBACK first with mem_we=1, mem_tag=0x20, mem_index=2. After ack, FILL with mem_tag=0x22. resp_way=0.
- mem_ack delayed 5 cycles: mem_req and mem_tag are held constant, req_ready=0, and extra req_valid pulses do not change state. Exactly one resp_valid.
- Assert reset during FILL: mem_req=0 in the same cycle without a clock edge. After release, a load of the same tag misses and ages are back to age[s][j]=j.
- Activity on idx3 leaves idx0 victim choice unchanged. Check that the ages in every set remain a permutation after each access.
